// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU engine feeding {HI,LO}.
// Define MULDIV_FAST_MULT_EN to complete multiplies in one cycle with a combinational multiplier.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  state_t state, state_next;

  logic [CW-1:0]      cnt;
  logic               is_div, neg_q, neg_r, div_zero;
  logic [WIDTH-1:0]   a_raw, y, rem, quo;
  logic [2*WIDTH-1:0] acc, x;

  logic               accept, last, fast_accept;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [2*WIDTH-1:0] mul_acc_next, final_result;
  logic [WIDTH:0]     shifted;
  logic               ge;
  logic [WIDTH-1:0]   diff, rem_next, quo_next;

  assign accept = start && (state != S_BUSY);
  assign last   = (state == S_BUSY) && (cnt == CW'(WIDTH - 1));
  assign busy   = (state == S_BUSY);
  assign done   = (state == S_DONE);

  // op[0]==0 selects the signed variants
  assign a_abs = (!op[0] && a[WIDTH-1]) ? (-a) : a;
  assign b_abs = (!op[0] && b[WIDTH-1]) ? (-b) : b;

`ifdef MULDIV_FAST_MULT_EN
  logic [2*WIDTH-1:0] fast_prod;
  // Low 2W bits of a 2W x 2W product are right for both signednesses once operands are extended.
  assign fast_prod = op[0] ? ({{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b})
                           : ({{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b});
  assign fast_accept = accept && !op[1];
`else
  assign fast_accept = 1'b0;
`endif

  assign mul_acc_next = acc + (y[0] ? x : '0);
  assign shifted      = {rem, quo[WIDTH-1]};
  assign ge           = shifted >= {1'b0, y};
  assign diff         = shifted[WIDTH-1:0] - y;
  assign rem_next     = ge ? diff : shifted[WIDTH-1:0];
  assign quo_next     = {quo[WIDTH-2:0], ge};

  // Final iteration result is folded straight into the output register.
  always_comb begin
    final_result = neg_q ? (-mul_acc_next) : mul_acc_next;
    if (is_div) begin
      if (div_zero)
        final_result = {a_raw, {WIDTH{1'b1}}};
      else
        final_result = {(neg_r ? (-rem_next) : rem_next), (neg_q ? (-quo_next) : quo_next)};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start) state_next = fast_accept ? S_DONE : S_BUSY;
      S_BUSY: if (last)  state_next = S_DONE;
      S_DONE: state_next = start ? (fast_accept ? S_DONE : S_BUSY) : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result <= '0;
      cnt    <= '0;
    end else if (accept) begin
      cnt      <= '0;
      is_div   <= op[1];
      neg_q    <= !op[0] && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r    <= !op[0] && a[WIDTH-1];
      div_zero <= (b == '0);
      a_raw    <= a;
      acc      <= '0;
      x        <= {{WIDTH{1'b0}}, a_abs};
      y        <= b_abs;
      rem      <= '0;
      quo      <= a_abs;
`ifdef MULDIV_FAST_MULT_EN
      if (!op[1]) result <= fast_prod;
`endif
    end else if (state == S_BUSY) begin
      cnt <= cnt + CW'(1);
      if (is_div) begin
        rem <= rem_next;
        quo <= quo_next;
      end else begin
        acc <= mul_acc_next;
        x   <= {x[2*WIDTH-2:0], 1'b0};
        y   <= {1'b0, y[WIDTH-1:1]};
      end
      if (last) result <= final_result;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit against an arithmetic timeline model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done;
  logic [63:0] result;

  int checks = 0;
  int failures = 0;
  bit started = 1'b0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [1:0] mop, input logic [31:0] ma, input logic [31:0] mb);
    longint sa, sb, q, r;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    case (mop)
      2'd0: return sa * sb;
      2'd1: return {32'd0, ma} * {32'd0, mb};
      2'd2: begin
        if (mb == 0) return {ma, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (mb == 0) return {ma, 32'hFFFF_FFFF};
        return {ma % mb, ma / mb};
      end
    endcase
  endfunction

  function automatic bit is_fast(input logic [1:0] fop);
`ifdef MULDIV_FAST_MULT_EN
    return !fop[1];
`else
    return 1'b0;
`endif
  endfunction

  // Timeline model: busy cycles remaining, then a done cycle carrying the pending result.
  int          m_cnt = 0;
  logic        m_done = 1'b0;
  logic [63:0] m_result = '0, m_pending = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_cnt <= 0;
      m_done <= 1'b0;
      m_result <= '0;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      m_done <= (m_cnt == 1);
      if (m_cnt == 1) m_result <= m_pending;
    end else if (start) begin
      if (is_fast(op)) begin
        m_result <= model(op, a, b);
        m_done <= 1'b1;
      end else begin
        m_pending <= model(op, a, b);
        m_cnt <= 32;
        m_done <= 1'b0;
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
    end
  endtask

  task automatic issue(input logic [1:0] iop, input logic [31:0] ia, input logic [31:0] ib);
    @(posedge clk); #1;
    start = 1'b1; op = iop; a = ia; b = ib;
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
  endtask

  task automatic wait_done(input string name, input logic [63:0] exp, input int lat);
    int n = 0;
    while (n < 60) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_done required=done_within_60", name);
    end else begin
      check(name, result, exp);
      if (lat > 0) check({name, "_latency"}, 64'(n), 64'(lat));
    end
  endtask

  function automatic int lat_of(input logic [1:0] lop);
    return is_fast(lop) ? 1 : 33;
  endfunction

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (started) begin
          check("cyc_busy", 64'(busy), 64'(m_cnt != 0));
          check("cyc_done", 64'(done), 64'(m_done));
          check("cyc_result", result, m_result);
        end
      end
      begin
        @(posedge clk); #1;
        started = 1'b1;
        @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_result", result, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu_max", 64'hFFFF_FFFE_0000_0001, lat_of(2'd1));
        issue(2'd0, 32'hFFFF_FFFD, 32'd5);
        wait_done("mult_neg3x5", 64'hFFFF_FFFF_FFFF_FFF1, lat_of(2'd0));
        issue(2'd0, 32'h8000_0000, 32'h8000_0000);
        wait_done("mult_minsq", 64'h4000_0000_0000_0000, lat_of(2'd0));
        issue(2'd3, 32'd7, 32'd2);
        wait_done("divu_7_2", 64'h0000_0001_0000_0003, 33);
        issue(2'd2, 32'hFFFF_FFF9, 32'd2);
        wait_done("div_m7_2", 64'hFFFF_FFFF_FFFF_FFFD, 33);
        issue(2'd2, 32'd7, 32'hFFFF_FFFE);
        wait_done("div_7_m2", 64'h0000_0001_FFFF_FFFD, 33);
        issue(2'd3, 32'd100, 32'd0);
        wait_done("divu_by0", 64'h0000_0064_FFFF_FFFF, 33);
        issue(2'd2, 32'hFFFF_FFF9, 32'd0);
        wait_done("div_by0", 64'hFFFF_FFF9_FFFF_FFFF, 33);
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_ovf", 64'h0000_0000_8000_0000, 33);

        // Start while busy must be ignored.
`ifdef MULDIV_FAST_MULT_EN
        issue(2'd3, 32'd12, 32'd1);
`else
        issue(2'd1, 32'd3, 32'd4);
`endif
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; op = 2'd1; a = 32'd9; b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("ignore_start", 64'd12, 0);

        issue(2'd3, 32'd50, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_result", result, 64'd0);
        issue(2'd3, 32'd50, 32'd7);
        wait_done("after_abort", 64'h0000_0001_0000_0007, 33);

        issue(2'd1, 32'd3, 32'd4);
        wait_done("b2b_first", 64'd12, lat_of(2'd1));
        start = 1'b1; op = 2'd3; a = 32'd20; b = 32'd6;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("b2b_busy", 64'(busy), 64'd1);
        wait_done("b2b_second", 64'h0000_0002_0000_0003, 32);

`ifdef MULDIV_FAST_MULT_EN
        issue(2'd0, 32'd6, 32'd7);
        wait_done("fast_mult", 64'd42, 1);
        check("fast_busy", 64'(busy), 64'd0);
`endif
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    join_any
  end

endmodule
